// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU memory-bus responder.
// Contents: FSM state enum, address-region enum, bus widths, default I/O base,
// read value returned on an I/O timeout, and the region decode helper.
package bus_pkg;

   localparam int unsigned ADDR_W = 27;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IO_AW  = 24;

   localparam logic [ADDR_W-1:0] IO_BASE_DEF = 27'h7000000;
   localparam logic [DATA_W-1:0] ERR_RDATA   = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      IO_WAIT  = 2'd2,
      ERR      = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_IO   = 2'd1,
      REG_NONE = 2'd2
   } region_e;

   // RAM owns every address whose bits above the RAM index are zero; I/O owns
   // everything from io_base upwards; the gap between them is unmapped.
   function automatic region_e decode_region(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       ram_aw,
                                             input logic [ADDR_W-1:0] io_base);
      if ((addr >> ram_aw) == '0) begin
         return REG_RAM;
      end else if (addr >= io_base) begin
         return REG_IO;
      end else begin
         return REG_NONE;
      end
   endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM, 2**AW words of DW bits, registered read port.
// Ports:
//   clk      - clock, rising edge
//   en_i     - access enable (read when we_i=0, write when we_i=1)
//   we_i     - write enable
//   addr_i   - word index
//   wdata_i  - write data
//   rdata_o  - read data, updated on an enabled read, held otherwise
// Contents and read register are not reset; all timing is owned by the caller.
module mem_bus_ram #(
   parameter int unsigned AW = 14,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   // Storage array and registered read.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_o <= mem_q[addr_i];
         end
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Target end of the CPU memory bus. Accepts single-word requests, decodes them
// to internal RAM, memory-mapped I/O (req/ack handshake) or unmapped space,
// returns read data on q and stalls the initiator with busy.
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   address, data, we     - request, sampled on the accepting edge
//   start                 - one-cycle request strobe, accepted only when idle
//   q                     - read data, held until the next read completes
//   busy                  - request in progress (combinational, high in start cycle)
//   io_addr/io_data/io_we - latched peripheral request (offset from IO_BASE)
//   io_req                - peripheral request level, held until io_ack
//   io_q, io_ack          - peripheral read data and one-cycle completion
//   bus_err               - one-cycle pulse on unmapped access or I/O timeout
// Optional feature: define BUS_TIMEOUT_EN to abort I/O requests that are not
// acknowledged within TIMEOUT_CYC cycles (read returns all ones, bus_err pulses).
module mem_bus_responder
   import bus_pkg::*;
#(
   parameter int unsigned       RAM_AW      = 14,
   parameter int unsigned       RAM_LAT     = 1,
   parameter logic [ADDR_W-1:0] IO_BASE     = IO_BASE_DEF,
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   input  logic              we,
   input  logic              start,
   output logic [DATA_W-1:0] q,
   output logic              busy,
   output logic [IO_AW-1:0]  io_addr,
   output logic [DATA_W-1:0] io_data,
   output logic              io_we,
   output logic              io_req,
   input  logic [DATA_W-1:0] io_q,
   input  logic              io_ack,
   output logic              bus_err
);

   // Counter only has to hold RAM_LAT-1.
   localparam int unsigned CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   if (RAM_LAT < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("mem_bus_responder: RAM_LAT and TIMEOUT_CYC must be >= 1");
   end

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [RAM_AW-1:0] idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;

   region_e           region_c;
   logic              accept_c;
   logic              ram_done_c;
   logic              ram_en_c;
   logic              ram_we_c;
   logic [RAM_AW-1:0] ram_addr_c;
   logic [DATA_W-1:0] ram_rdata;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TMO_W-1:0] tmo_q;
`endif

   // Request acceptance and decode of the incoming request.
   assign region_c   = decode_region(address, RAM_AW, IO_BASE);
   assign accept_c   = start && (state_q == IDLE);
   assign busy       = (state_q != IDLE) || accept_c;

   // RAM reads are launched on the accepting edge so data is ready by the final
   // edge; writes are committed only on the final edge so a reset before it
   // discards them.
   assign ram_done_c = (state_q == RAM_WAIT) && (cnt_q == '0);
   assign ram_we_c   = ram_done_c && we_q;
   assign ram_en_c   = ram_we_c || (accept_c && (region_c == REG_RAM) && !we);
   assign ram_addr_c = accept_c ? address[RAM_AW-1:0] : idx_q;

   mem_bus_ram #(
      .AW (RAM_AW),
      .DW (DATA_W)
   ) u_ram (
      .clk     (clk),
      .en_i    (ram_en_c),
      .we_i    (ram_we_c),
      .addr_i  (ram_addr_c),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Request FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         q       <= '0;
         io_addr <= '0;
         io_data <= '0;
         io_we   <= 1'b0;
         io_req  <= 1'b0;
         bus_err <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         bus_err <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q   <= address[RAM_AW-1:0];
                  wdata_q <= data;
                  we_q    <= we;
                  case (region_c)
                     REG_RAM: begin
                        state_q <= RAM_WAIT;
                        cnt_q   <= CNT_W'(RAM_LAT - 1);
                     end
                     REG_IO: begin
                        state_q <= IO_WAIT;
                        io_req  <= 1'b1;
                        io_addr <= IO_AW'(address - IO_BASE);
                        io_data <= data;
                        io_we   <= we;
`ifdef BUS_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                     end
                     default: begin
                        state_q <= ERR;
                        bus_err <= 1'b1;
                     end
                  endcase
               end
            end
            RAM_WAIT: begin
               if (cnt_q == '0) begin
                  if (!we_q) begin
                     q <= ram_rdata;
                  end
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            IO_WAIT: begin
               // An ack on the timeout cycle takes priority over the abort.
               if (io_ack) begin
                  io_req <= 1'b0;
                  if (!we_q) begin
                     q <= io_q;
                  end
                  state_q <= IDLE;
               end
`ifdef BUS_TIMEOUT_EN
               else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                  io_req  <= 1'b0;
                  bus_err <= 1'b1;
                  if (!we_q) begin
                     q <= ERR_RDATA;
                  end
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
`endif
            end
            ERR: begin
               if (!we_q) begin
                  q <= '0;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_bus_responder;
   import bus_pkg::*;

   localparam int unsigned       RAM_AW  = 14;
   localparam int unsigned       RAM_LAT = 1;
   localparam int unsigned       TMO     = 8;
   localparam logic [ADDR_W-1:0] IO_B    = 27'h7000000;

   logic        clk;
   logic        reset;
   logic [26:0] address;
   logic [31:0] data;
   logic        we;
   logic        start;
   logic [31:0] q;
   logic        busy;
   logic [23:0] io_addr;
   logic [31:0] io_data;
   logic        io_we;
   logic        io_req;
   logic [31:0] io_q;
   logic        io_ack;
   logic        bus_err;

   mem_bus_responder #(
      .RAM_AW      (RAM_AW),
      .RAM_LAT     (RAM_LAT),
      .IO_BASE     (IO_B),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .address (address),
      .data    (data),
      .we      (we),
      .start   (start),
      .q       (q),
      .busy    (busy),
      .io_addr (io_addr),
      .io_data (io_data),
      .io_we   (io_we),
      .io_req  (io_req),
      .io_q    (io_q),
      .io_ack  (io_ack),
      .bus_err (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: what the outputs must be in the current cycle.
   logic [31:0] exp_q;
   bit          q_known;
   bit          exp_busy, exp_err, exp_ioreq, err_pending, chk_en;
   logic [23:0] exp_io_addr;
   logic [31:0] exp_io_data;
   logic        exp_io_we;
   bit          pin_q_en, pin_io_en;
   logic [31:0] pin_q_val;
   logic [23:0] pin_io_val;
   logic [31:0] mem_m [int];
   int          checks = 0;
   int          errors = 0;

   int unsigned ram_set [8] = '{0, 1, 32'h10, 32'h11, 32'h2A5, 32'h1FFF, 32'h2000, 32'h3FFF};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Single compare process, sampling on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_q", q, 32'd0);
         chk("rst_io_req", 32'(io_req), 32'd0);
         chk("rst_bus_err", 32'(bus_err), 32'd0);
         chk("rst_io_addr", 32'(io_addr), 32'd0);
         chk("rst_io_data", io_data, 32'd0);
         chk("rst_io_we", 32'(io_we), 32'd0);
      end else if (chk_en) begin
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("bus_err", 32'(bus_err), 32'(exp_err));
         chk("io_req", 32'(io_req), 32'(exp_ioreq));
         if (q_known) chk("q", q, exp_q);
         if (exp_ioreq) begin
            chk("io_addr", 32'(io_addr), 32'(exp_io_addr));
            chk("io_data", io_data, exp_io_data);
            chk("io_we", 32'(io_we), 32'(exp_io_we));
            if (pin_io_en) chk("pin_io_addr", 32'(io_addr), 32'(pin_io_val));
         end
         if (pin_q_en) chk("pin_q", q, pin_q_val);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int region_of(input logic [26:0] a);
      if (a < 27'(1 << RAM_AW)) return 0;
      if (a >= IO_B) return 1;
      return 2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Junk on inputs that the responder must ignore while busy.
   task automatic noise();
      start   = 1'($urandom_range(0, 1));
      address = 27'($urandom);
      data    = $urandom;
      we      = 1'($urandom_range(0, 1));
      io_ack  = 1'($urandom_range(0, 1));
      io_q    = $urandom;
   endtask

   task automatic run_txn(input logic [26:0] a, input logic [31:0] d, input logic w,
                          input int ack_dly, input logic [31:0] io_rd);
      int          rg;
      int          idx;
      int          n;
      bit          timed_out;
      logic [26:0] off;
      rg  = region_of(a);
      idx = int'(a[RAM_AW-1:0]);
      address = a; data = d; we = w; start = 1'b1;
      io_ack = 1'($urandom_range(0, 1)); io_q = $urandom;
      exp_busy = 1; exp_err = 0; exp_ioreq = 0;
      step();
      if (rg == 0) begin
         for (int i = 0; i < int'(RAM_LAT); i++) begin
            noise();
            step();
         end
         if (w) mem_m[idx] = d;
         else if (mem_m.exists(idx)) begin exp_q = mem_m[idx]; q_known = 1; end
         else q_known = 0;
      end else if (rg == 2) begin
         exp_err = 1;
         noise();
         step();
         exp_err = 0;
         if (!w) begin exp_q = 32'd0; q_known = 1; end
      end else begin
         off = a - IO_B;
         exp_io_addr = off[23:0]; exp_io_data = d; exp_io_we = w; exp_ioreq = 1;
         timed_out = 0;
         n = ack_dly + 1;
`ifdef BUS_TIMEOUT_EN
         if (ack_dly >= int'(TMO)) begin timed_out = 1; n = int'(TMO); end
`endif
         for (int k = 0; k < n; k++) begin
            noise();
            io_ack = (!timed_out && k == n - 1);
            io_q   = io_ack ? io_rd : $urandom;
            step();
         end
         io_ack = 0; exp_ioreq = 0;
         if (!w) begin exp_q = timed_out ? 32'hFFFFFFFF : io_rd; q_known = 1; end
         err_pending = timed_out;
      end
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         start = 0; exp_busy = 0; exp_ioreq = 0;
         exp_err = err_pending; err_pending = 0;
         io_ack = 1'($urandom_range(0, 1)); io_q = $urandom; address = 27'($urandom);
         step();
         pin_q_en = 0;
      end
   endtask

   task automatic idle_pin(input logic [31:0] v);
      pin_q_en = 1; pin_q_val = v;
      idle(1);
   endtask

   // Assert reset mid-cycle (async), hold across one edge, release mid-cycle.
   task automatic reset_now();
      #2;
      reset = 1; start = 0; io_ack = 0;
      @(posedge clk);
      #2;
      exp_q = 32'd0; q_known = 1; exp_busy = 0; exp_ioreq = 0; exp_err = 0; err_pending = 0;
      reset = 0;
      step();
   endtask

   initial begin
      reset = 1; start = 0; address = '0; data = '0; we = 0; io_q = '0; io_ack = 0;
      chk_en = 0; exp_q = 32'd0; q_known = 1; exp_busy = 0; exp_err = 0; exp_ioreq = 0;
      err_pending = 0; pin_q_en = 0; pin_io_en = 0;
      exp_io_addr = '0; exp_io_data = '0; exp_io_we = 0;
      repeat (2) @(posedge clk);
      #3 reset = 0; chk_en = 1;
      step();

      // RAM write then read of 0x10.
      run_txn(27'h10, 32'hDEADBEEF, 1'b1, 0, 32'd0);
      idle(1);
      run_txn(27'h10, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'hDEADBEEF);

      // Back-to-back write/read of 0x11.
      run_txn(27'h11, 32'h12345678, 1'b1, 0, 32'd0);
      run_txn(27'h11, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'h12345678);

      // I/O read, ack in the third request cycle.
      pin_io_en = 1; pin_io_val = 24'h4;
      run_txn(27'h7000004, 32'h0, 1'b0, 2, 32'hA5A5A5A5);
      pin_io_en = 0;
      idle_pin(32'hA5A5A5A5);

      // Unmapped read and write; RAM[0] must survive.
      run_txn(27'h0, 32'hCAFE0000, 1'b1, 0, 32'd0);
      run_txn(27'h0100000, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'd0);
      run_txn(27'h0100000, 32'h11111111, 1'b1, 0, 32'd0);
      run_txn(27'h0, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'hCAFE0000);

      // Reset while io_req is high, then a normal RAM read.
      address = 27'h7000010; data = 32'h0BADC0DE; we = 0; start = 1; io_ack = 0;
      exp_busy = 1; exp_ioreq = 0; exp_err = 0;
      step();
      start = 0; exp_ioreq = 1; exp_io_addr = 24'h10; exp_io_data = 32'h0BADC0DE; exp_io_we = 0;
      step();
      reset_now();
      run_txn(27'h10, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'hDEADBEEF);

      // Reset before the final edge of a RAM write: write is dropped.
      address = 27'h10; data = 32'h0; we = 1; start = 1; io_ack = 0;
      exp_busy = 1;
      step();
      start = 0;
      reset_now();
      run_txn(27'h10, 32'd0, 1'b0, 0, 32'd0);
      idle_pin(32'hDEADBEEF);

`ifdef BUS_TIMEOUT_EN
      // Never-acked read times out; ack on the last allowed cycle wins.
      run_txn(27'h7000020, 32'd0, 1'b0, 1000, 32'd0);
      idle_pin(32'hFFFFFFFF);
      run_txn(27'h7000020, 32'd0, 1'b0, int'(TMO) - 1, 32'h600DF00D);
      idle_pin(32'h600DF00D);
`endif

      // Randomized traffic.
      foreach (ram_set[i]) run_txn(27'(ram_set[i]), $urandom, 1'b1, 0, 32'd0);
      for (int t = 0; t < 300; t++) begin
         logic [26:0] a;
         int          r;
         int          dly;
         int          gap;
         r = $urandom_range(0, 9);
         if (r < 5) a = 27'(ram_set[$urandom_range(0, 7)]);
         else if (r < 8) begin
            case ($urandom_range(0, 2))
               0:       a = IO_B;
               1:       a = 27'h7FFFFFF;
               default: a = IO_B + 27'($urandom_range(0, 255));
            endcase
         end else begin
            case ($urandom_range(0, 3))
               0:       a = 27'h4000;
               1:       a = 27'h6FFFFFF;
               2:       a = 27'h0100000;
               default: a = 27'($urandom_range(32'h4000, 32'h6FFFFFF));
            endcase
         end
         dly = $urandom_range(0, 4);
`ifdef BUS_TIMEOUT_EN
         if ($urandom_range(0, 3) == 0) dly = $urandom_range(0, 12);
`endif
         run_txn(a, $urandom, 1'($urandom_range(0, 1)), dly, $urandom);
         gap = $urandom_range(0, 2);
         if (err_pending && gap == 0) gap = 1;
         idle(gap);
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Target end of the CPU memory bus: accepts single-word requests (address/data/we/start), returns read data on q and stalls the initiator with busy.
- Decodes each request to one of three regions:
  - internal RAM;
  - memory-mapped I/O, forwarded over a req/ack port to peripherals;
  - unmapped, which is error-terminated.
- Sits between CPU and memory/peripherals.

Parameters:
- RAM_AW, 14: internal RAM address width in words; RAM_WORDS = 2**RAM_AW.
- RAM_LAT, 1: extra cycles of RAM access latency; must be >= 1.
- IO_BASE, 27'h7000000: start of I/O region; I/O region is address >= IO_BASE.
- TIMEOUT_CYC, 255: I/O ack timeout in cycles; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  27  word address from initiator; sampled when start is accepted.
- data  in  32  write data; sampled when start is accepted.
- we  in  1  1 = write, 0 = read; sampled when start is accepted.
- start  in  1  one-cycle request strobe.
- q  out  32  read data; registered, held until the next read completes.
- busy  out  1  request in progress.
- io_addr  out  24  latched address - IO_BASE (low 24 bits).
- io_data  out  32  latched write data to peripheral.
- io_we  out  1  latched write enable to peripheral.
- io_req  out  1  peripheral request; level, held until ack.
- io_q  in  32  peripheral read data; valid with io_ack.
- io_ack  in  1  peripheral completion; one cycle.
- bus_err  out  1  one-cycle pulse on unmapped access or timeout.

Behaviour:
- Reset (async, immediate): state IDLE; q=0, io_req=0, io_addr=0, io_data=0, io_we=0, bus_err=0; counters 0. RAM contents are not reset.
- States: IDLE, RAM_WAIT, IO_WAIT, ERR.
- busy = (state != IDLE) | (start & state == IDLE). Combinational, so busy is high in the start cycle with no gap.
- Acceptance: start is accepted only in IDLE. start in any other state is ignored; the in-flight request is unaffected.
- Request latch: address, data and we are latched on the accepting edge.
- Decode (on the latched request):
  - RAM if address[26:RAM_AW] == 0;
  - else IO if address >= IO_BASE;
  - else unmapped.
- RAM path: IDLE -> RAM_WAIT, counter loaded with RAM_LAT-1.
  - Counter decrements each cycle.
  - On the edge where counter == 0:
    - read: q <= mem[addr];
    - write: mem[addr] <= data, q unchanged;
    - state -> IDLE.
  - Start accepted at cycle T: busy high T..T+RAM_LAT, low from T+RAM_LAT+1 with q valid.
- IO path: IDLE -> IO_WAIT.
  - io_req rises the cycle after start, together with io_addr, io_data and io_we.
  - io_req and the io_* outputs stay stable until io_ack is sampled high.
  - On the ack edge:
    - io_req <= 0;
    - read: q <= io_q;
    - state -> IDLE.
  - Minimum: busy high 2 cycles when ack arrives in the first req cycle.
  - io_ack while io_req == 0 is ignored.
- Unmapped path: IDLE -> ERR for one cycle, then IDLE.
  - Read: q <= 0.
  - Write: discarded.
  - bus_err is high during the ERR cycle.
- Back-to-back requests: start in the first cycle busy is low is accepted. There are no dead cycles.
- Reset mid-operation:
  - an in-flight RAM write whose final edge has not occurred is not performed;
  - io_req drops asynchronously.
- Widths and wrap: RAM index = address[RAM_AW-1:0]. io_addr = (address - IO_BASE)[23:0]; no wrap beyond 24 bits.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - IO_WAIT counts cycles from io_req rise.
  - If TIMEOUT_CYC cycles pass with no io_ack, the request is aborted:
    - io_req <= 0;
    - read: q <= 32'hFFFFFFFF;
    - bus_err pulses for one cycle;
    - state -> IDLE.
  - An ack arriving on the timeout cycle wins.
- Undefined: IO_WAIT waits indefinitely; no counter is synthesized.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, RAM_WAIT, IO_WAIT, ERR);
  - region enum (REG_RAM, REG_IO, REG_NONE);
  - bus width constants (ADDR_W=27, DATA_W=32, IO_AW=24);
  - default IO_BASE;
  - error read value 32'hFFFFFFFF.
- Sub-module mem_bus_ram: single-port synchronous RAM, RAM_WORDS x 32, with write enable. The FSM owns all timing.

Test Plan:
- RAM write/read, RAM_LAT=1: write 32'hDEADBEEF to 0x10, then read 0x10 -> busy high exactly 2 cycles each; q=32'hDEADBEEF when busy falls.
- Back-to-back: issue start the first cycle busy is low, reading 0x11 after a write to 0x11 of 32'h12345678 -> accepted with no dead cycle; q=32'h12345678.
- IO read: start with address=27'h7000004, we=0; peripheral acks 3 cycles after io_req rises with io_q=32'hA5A5A5A5 -> io_addr=4, io_req held 3 cycles, q=32'hA5A5A5A5, busy low the cycle after ack.
- Unmapped: read address 27'h0100000 (RAM_AW=14) -> one ERR cycle, q=0, bus_err pulse of 1 cycle, busy high 2 cycles; a write there does not alter RAM[0].
- Reset mid-IO: assert reset while io_req=1 -> io_req, busy and bus_err go 0 immediately; after release a RAM read works normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=8: IO read never acked -> io_req drops after 8 cycles, q=32'hFFFFFFFF, bus_err pulses once.
